// File: rtl/noc_rx_queue_if.sv
// Valid/ready packet stream. The payload type is a parameter, so this file
// does not depend on the packet package.
interface noc_rx_queue_if #(
    parameter type pkt_t = logic
);
    pkt_t pkt;
    logic valid;
    logic ready;

    modport master (output pkt, output valid, input ready);
    modport slave  (input pkt, input valid, output ready);
endinterface

// File: rtl/noc_rx_queue.sv
// Per-link NoC receive buffer: classifies incoming packets into divergence and
// clause queues, filters drops, and re-emits one stream with clause anti-starvation.
package satswarmv2_pkg;
    localparam int CORE_ID_W = 4;

    typedef enum logic [2:0] {
        MSG_NOP     = 3'd0,
        MSG_DIVERGE = 3'd1,
        MSG_CLAUSE  = 3'd2,
        MSG_SYNC    = 3'd3
    } msg_type_t;

    typedef struct packed {
        msg_type_t              msg_type;
        logic [CORE_ID_W-1:0]   src_id;
        logic [7:0]             quality_metric;
        logic [31:0]            payload;
    } noc_packet_t;
endpackage

module noc_rx_queue #(
    parameter int CORE_ID    = 0,
    parameter int CORE_ID_W  = satswarmv2_pkg::CORE_ID_W,
    parameter int DIV_DEPTH  = 2,
    parameter int CLS_DEPTH  = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    noc_rx_queue_if.slave               i_in,
    noc_rx_queue_if.master              o_out,
    input  logic [7:0]                  i_cfg_lbd_max,
    output logic [15:0]                 o_drop_self,
    output logic [15:0]                 o_drop_lbd,
    output logic [15:0]                 o_drop_type,
    output logic [$clog2(DIV_DEPTH):0]  o_div_count,
    output logic [$clog2(CLS_DEPTH):0]  o_cls_count
);
    import satswarmv2_pkg::*;

    localparam int DAW   = $clog2(DIV_DEPTH);
    localparam int CAW   = $clog2(CLS_DEPTH);
    localparam int DCW   = DAW + 1;
    localparam int CCW   = CAW + 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [CORE_ID_W-1:0] SELF_ID = CORE_ID_W'(CORE_ID);
    localparam logic [STV_W-1:0]     STV_MAX = STV_W'(STARVE_LIM);

    typedef enum logic [2:0] {
        K_SELF,
        K_DIV,
        K_LBD,
        K_CLS,
        K_TYPE
    } pkt_class_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DIV,
        SEL_CLS
    } sel_t;

    noc_packet_t w_in_pkt;
    pkt_class_t  w_class;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_push_div;
    logic        w_push_cls;

    logic [DAW-1:0] r_div_wr, r_div_rd;
    logic [DCW-1:0] r_div_cnt, w_div_left;
    noc_packet_t    r_div_mem [DIV_DEPTH];
    logic [CAW-1:0] r_cls_wr, r_cls_rd;
    logic [CCW-1:0] r_cls_cnt, w_cls_left;
    noc_packet_t    r_cls_mem [CLS_DEPTH];

    logic        w_div_full, w_cls_full;
    logic        w_div_avail, w_cls_avail;
    noc_packet_t w_div_head, w_cls_head;

    sel_t             r_sel, w_sel_next;
    logic [STV_W-1:0] r_stv, w_stv_next;
    noc_packet_t      r_out_pkt, w_out_next;
    logic             w_hs;
    logic             w_pop_div, w_pop_cls;

    logic [15:0] r_drop_self, r_drop_lbd, r_drop_type;

    assign w_in_pkt = i_in.pkt;

    // Priority order matters: loopback beats everything, and the LBD filter
    // only ever applies to clauses.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_class = K_TYPE;
        if (w_in_pkt.src_id == SELF_ID) begin
            w_class = K_SELF;
        end else if (w_in_pkt.msg_type == MSG_DIVERGE) begin
            w_class = K_DIV;
        end else if (w_in_pkt.msg_type == MSG_CLAUSE) begin
            w_class = (w_in_pkt.quality_metric > i_cfg_lbd_max) ? K_LBD : K_CLS;
        end
    end

    assign w_div_full = (r_div_cnt == DCW'(DIV_DEPTH));
    assign w_cls_full = (r_cls_cnt == CCW'(CLS_DEPTH));

    always_comb begin
        w_in_ready = 1'b1;
        if (w_class == K_DIV) begin
            w_in_ready = !w_div_full;
        end else if (w_class == K_CLS) begin
            w_in_ready = !w_cls_full;
        end
    end

    assign i_in.ready = w_in_ready;
    assign w_accept   = i_in.valid && w_in_ready;
    assign w_push_div = w_accept && (w_class == K_DIV);
    assign w_push_cls = w_accept && (w_class == K_CLS);

    assign w_hs      = o_out.valid && o_out.ready;
    assign w_pop_div = w_hs && (r_sel == SEL_DIV);
    assign w_pop_cls = w_hs && (r_sel == SEL_CLS);

    // The presented packet stays in its queue until the handshake pops it.
    // On a handshake the next head may be the packet being pushed right now,
    // which keeps a one-deep stream running without bubbles.
    assign w_div_left  = r_div_cnt - DCW'(w_pop_div);
    assign w_cls_left  = r_cls_cnt - CCW'(w_pop_cls);
    assign w_div_avail = (w_div_left != '0) || (w_hs && w_push_div);
    assign w_cls_avail = (w_cls_left != '0) || (w_hs && w_push_cls);
    assign w_div_head  = (w_div_left != '0) ? r_div_mem[r_div_rd + DAW'(w_pop_div)] : w_in_pkt;
    assign w_cls_head  = (w_cls_left != '0) ? r_cls_mem[r_cls_rd + CAW'(w_pop_cls)] : w_in_pkt;

    // NOTE: queue storage has no reset; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push_div) begin
            r_div_mem[r_div_wr] <= w_in_pkt;
        end
        if (w_push_cls) begin
            r_cls_mem[r_cls_wr] <= w_in_pkt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_wr  <= '0;
            r_div_rd  <= '0;
            r_div_cnt <= '0;
            r_cls_wr  <= '0;
            r_cls_rd  <= '0;
            r_cls_cnt <= '0;
        end else begin
            if (w_push_div) r_div_wr <= r_div_wr + DAW'(1);
            if (w_pop_div)  r_div_rd <= r_div_rd + DAW'(1);
            if (w_push_cls) r_cls_wr <= r_cls_wr + CAW'(1);
            if (w_pop_cls)  r_cls_rd <= r_cls_rd + CAW'(1);
            r_div_cnt <= r_div_cnt + DCW'(w_push_div) - DCW'(w_pop_div);
            r_cls_cnt <= r_cls_cnt + CCW'(w_push_cls) - CCW'(w_pop_cls);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_self <= '0;
            r_drop_lbd  <= '0;
            r_drop_type <= '0;
        end else if (w_accept) begin
            if (w_class == K_SELF && r_drop_self != 16'hFFFF) r_drop_self <= r_drop_self + 16'd1;
            if (w_class == K_LBD  && r_drop_lbd  != 16'hFFFF) r_drop_lbd  <= r_drop_lbd  + 16'd1;
            if (w_class == K_TYPE && r_drop_type != 16'hFFFF) r_drop_type <= r_drop_type + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= SEL_NONE;
            r_stv     <= '0;
            r_out_pkt <= '0;
        end else begin
            r_sel     <= w_sel_next;
            r_stv     <= w_stv_next;
            r_out_pkt <= w_out_next;
        end
    end

    // Selection is only revisited when idle or on a handshake, so a stalled
    // head is never replaced.
    always_comb begin
        w_stv_next = r_stv;
        w_sel_next = r_sel;
        w_out_next = r_out_pkt;

        if (w_hs) begin
            if (r_sel == SEL_DIV && r_cls_cnt != '0) begin
                if (r_stv != STV_MAX) w_stv_next = r_stv + STV_W'(1);
            end else begin
                w_stv_next = '0;
            end
        end

        if (r_sel == SEL_NONE || w_hs) begin
            w_sel_next = SEL_NONE;
            if (w_cls_avail && (w_stv_next == STV_MAX || !w_div_avail)) begin
                w_sel_next = SEL_CLS;
                w_out_next = w_cls_head;
            end else if (w_div_avail) begin
                w_sel_next = SEL_DIV;
                w_out_next = w_div_head;
            end
        end
    end

    assign o_out.valid = (r_sel != SEL_NONE);
    assign o_out.pkt   = r_out_pkt;
    assign o_drop_self = r_drop_self;
    assign o_drop_lbd  = r_drop_lbd;
    assign o_drop_type = r_drop_type;
    assign o_div_count = r_div_cnt;
    assign o_cls_count = r_cls_cnt;
endmodule

// File: tb/tb_noc_rx_queue.sv
// Directed bench for noc_rx_queue: classification, drops, back-pressure,
// lock-while-stalled, starvation bound and asynchronous reset.
module tb_noc_rx_queue;
    import satswarmv2_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg;
    logic [15:0] d_self, d_lbd, d_type;
    logic [1:0]  div_cnt;
    logic [2:0]  cls_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    noc_packet_t zero_pkt = '0;

    noc_rx_queue_if #(.pkt_t(noc_packet_t)) in_if ();
    noc_rx_queue_if #(.pkt_t(noc_packet_t)) out_if ();

    always #5 clk = ~clk;

    noc_rx_queue #(
        .CORE_ID    (0),
        .DIV_DEPTH  (2),
        .CLS_DEPTH  (4),
        .STARVE_LIM (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_in          (in_if),
        .o_out         (out_if),
        .i_cfg_lbd_max (cfg),
        .o_drop_self   (d_self),
        .o_drop_lbd    (d_lbd),
        .o_drop_type   (d_type),
        .o_div_count   (div_cnt),
        .o_cls_count   (cls_cnt)
    );

    function automatic noc_packet_t mk(msg_type_t t, logic [3:0] src, logic [7:0] qm, logic [31:0] pl);
        noc_packet_t p;
        p.msg_type       = t;
        p.src_id         = src;
        p.quality_metric = qm;
        p.payload        = pl;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg = 8'd6;
        in_if.valid = 1'b0;
        in_if.pkt = mk(MSG_CLAUSE, 4'd1, 8'd3, 32'h1);
        out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_if.valid); end
        n_cmp++; if (out_if.pkt !== zero_pkt) begin n_bad++; $display("FAIL rst_out_pkt: got %h want 0", out_if.pkt); end
        n_cmp++; if ({d_self, d_lbd, d_type} !== 48'd0) begin n_bad++; $display("FAIL rst_drops: got %h/%h/%h want 0", d_self, d_lbd, d_type); end
        n_cmp++; if ({div_cnt, cls_cnt} !== 5'd0) begin n_bad++; $display("FAIL rst_counts: got %0d/%0d want 0", div_cnt, cls_cnt); end
        n_cmp++; if (in_if.ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_if.ready); end
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b want 0", out_if.valid); end
    endtask

    task automatic test_single_clause();
        noc_packet_t p;
        p = mk(MSG_CLAUSE, 4'd1, 8'd3, 32'hA5A5_0001);
        in_if.pkt = p;
        in_if.valid = 1'b1;
        #1;
        n_cmp++; if (in_if.ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready: got %b want 1", in_if.ready); end
        tick();
        in_if.valid = 1'b0;
        n_cmp++; if (cls_cnt !== 3'd1) begin n_bad++; $display("FAIL single_cls_cnt: got %0d want 1", cls_cnt); end
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", out_if.valid); end
        tick();
        n_cmp++; if (out_if.valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_if.valid); end
        n_cmp++; if (out_if.pkt !== p) begin n_bad++; $display("FAIL single_pkt: got %h want %h", out_if.pkt, p); end
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL single_after_valid: got %b want 0", out_if.valid); end
        n_cmp++; if (cls_cnt !== 3'd0) begin n_bad++; $display("FAIL single_after_cnt: got %0d want 0", cls_cnt); end
    endtask

    task automatic test_drops();
        noc_packet_t pk [3];
        pk[0] = mk(MSG_CLAUSE,  4'd1, 8'd7, 32'h0000_D001);
        pk[1] = mk(MSG_DIVERGE, 4'd0, 8'd0, 32'h0000_D002);
        pk[2] = mk(MSG_SYNC,    4'd2, 8'd0, 32'h0000_D003);
        cfg = 8'd6;
        for (int i = 0; i < 3; i++) begin
            in_if.pkt = pk[i];
            in_if.valid = 1'b1;
            #1;
            n_cmp++; if (in_if.ready !== 1'b1) begin n_bad++; $display("FAIL drop_in_ready[%0d]: got %b want 1", i, in_if.ready); end
            tick();
            n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL drop_out_valid[%0d]: got %b want 0", i, out_if.valid); end
        end
        in_if.valid = 1'b0;
        n_cmp++; if (d_lbd !== 16'd1) begin n_bad++; $display("FAIL drop_lbd: got %0d want 1", d_lbd); end
        n_cmp++; if (d_self !== 16'd1) begin n_bad++; $display("FAIL drop_self: got %0d want 1", d_self); end
        n_cmp++; if (d_type !== 16'd1) begin n_bad++; $display("FAIL drop_type: got %0d want 1", d_type); end
        n_cmp++; if ({div_cnt, cls_cnt} !== 5'd0) begin n_bad++; $display("FAIL drop_counts: got %0d/%0d want 0", div_cnt, cls_cnt); end
        tick();
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL drop_late_valid: got %b want 0", out_if.valid); end
    endtask

    task automatic test_lbd_boundary();
        noc_packet_t p1, p2;
        p1 = mk(MSG_CLAUSE, 4'd1, 8'd6,   32'hB000_0006);
        p2 = mk(MSG_CLAUSE, 4'd2, 8'hFF, 32'hB000_00FF);
        cfg = 8'd6;
        in_if.pkt = p1;
        in_if.valid = 1'b1;
        tick();
        cfg = 8'hFF;
        in_if.pkt = p2;
        tick();
        in_if.valid = 1'b0;
        cfg = 8'd0;
        n_cmp++; if (cls_cnt !== 3'd2) begin n_bad++; $display("FAIL lbd_cls_cnt: got %0d want 2", cls_cnt); end
        n_cmp++; if (d_lbd !== 16'd1) begin n_bad++; $display("FAIL lbd_drop_cnt: got %0d want 1", d_lbd); end
        n_cmp++; if (out_if.pkt !== p1) begin n_bad++; $display("FAIL lbd_first: got %h want %h", out_if.pkt, p1); end
        out_if.ready = 1'b1;
        tick();
        n_cmp++; if (out_if.valid !== 1'b1 || out_if.pkt !== p2) begin n_bad++; $display("FAIL lbd_second: got %b/%h want 1/%h", out_if.valid, out_if.pkt, p2); end
        tick();
        out_if.ready = 1'b0;
        cfg = 8'd6;
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL lbd_drained: got %b want 0", out_if.valid); end
    endtask

    task automatic test_fill();
        noc_packet_t q [5];
        for (int i = 0; i < 5; i++) q[i] = mk(MSG_CLAUSE, 4'd1, 8'(i), 32'hC000_0000 + i);
        out_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_if.pkt = q[i];
            in_if.valid = 1'b1;
            #1;
            n_cmp++; if (in_if.ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d]: got %b want 1", i, in_if.ready); end
            tick();
        end
        in_if.pkt = q[4];
        #1;
        n_cmp++; if (cls_cnt !== 3'd4) begin n_bad++; $display("FAIL fill_full_cnt: got %0d want 4", cls_cnt); end
        n_cmp++; if (in_if.ready !== 1'b0) begin n_bad++; $display("FAIL fill_blocked: got %b want 0", in_if.ready); end
        n_cmp++; if (out_if.pkt !== q[0]) begin n_bad++; $display("FAIL fill_head: got %h want %h", out_if.pkt, q[0]); end
        tick();
        out_if.ready = 1'b1;
        #1;
        n_cmp++; if (in_if.ready !== 1'b0) begin n_bad++; $display("FAIL fill_same_cycle_pop: got %b want 0", in_if.ready); end
        tick();
        out_if.ready = 1'b0;
        n_cmp++; if (in_if.ready !== 1'b1) begin n_bad++; $display("FAIL fill_after_pop: got %b want 1", in_if.ready); end
        n_cmp++; if (cls_cnt !== 3'd3) begin n_bad++; $display("FAIL fill_cnt_after_pop: got %0d want 3", cls_cnt); end
        n_cmp++; if (out_if.pkt !== q[1]) begin n_bad++; $display("FAIL fill_next_head: got %h want %h", out_if.pkt, q[1]); end
        tick();
        in_if.valid = 1'b0;
        n_cmp++; if (cls_cnt !== 3'd4) begin n_bad++; $display("FAIL fill_fifth_in: got %0d want 4", cls_cnt); end
        out_if.ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            n_cmp++; if (out_if.valid !== 1'b1 || out_if.pkt !== q[k]) begin n_bad++; $display("FAIL fill_drain[%0d]: got %b/%h want 1/%h", k, out_if.valid, out_if.pkt, q[k]); end
            tick();
        end
        out_if.ready = 1'b0;
        n_cmp++; if (out_if.valid !== 1'b0 || cls_cnt !== 3'd0) begin n_bad++; $display("FAIL fill_empty: got %b/%0d want 0/0", out_if.valid, cls_cnt); end
    endtask

    task automatic test_no_preempt();
        noc_packet_t cx, dx;
        cx = mk(MSG_CLAUSE,  4'd3, 8'd1, 32'h0000_00CC);
        dx = mk(MSG_DIVERGE, 4'd2, 8'd9, 32'h0000_00DD);
        out_if.ready = 1'b0;
        in_if.pkt = cx;
        in_if.valid = 1'b1;
        tick();
        in_if.valid = 1'b0;
        tick();
        in_if.pkt = dx;
        in_if.valid = 1'b1;
        tick();
        in_if.valid = 1'b0;
        tick();
        n_cmp++; if (out_if.pkt !== cx) begin n_bad++; $display("FAIL preempt_hold: got %h want %h", out_if.pkt, cx); end
        n_cmp++; if (div_cnt !== 2'd1 || cls_cnt !== 3'd1) begin n_bad++; $display("FAIL preempt_counts: got %0d/%0d want 1/1", div_cnt, cls_cnt); end
        tick();
        n_cmp++; if (out_if.valid !== 1'b1 || out_if.pkt !== cx) begin n_bad++; $display("FAIL preempt_hold2: got %b/%h want 1/%h", out_if.valid, out_if.pkt, cx); end
        out_if.ready = 1'b1;
        tick();
        n_cmp++; if (out_if.valid !== 1'b1 || out_if.pkt !== dx) begin n_bad++; $display("FAIL preempt_div_next: got %b/%h want 1/%h", out_if.valid, out_if.pkt, dx); end
        tick();
        out_if.ready = 1'b0;
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL preempt_empty: got %b want 0", out_if.valid); end
    endtask

    task automatic test_starvation();
        noc_packet_t a, b, c;
        noc_packet_t d [10];
        noc_packet_t exp_q [6];
        noc_packet_t got [$];
        int idx;
        logic acc;
        a = mk(MSG_DIVERGE, 4'd1, 8'd0, 32'hD000_0001);
        b = mk(MSG_DIVERGE, 4'd2, 8'd0, 32'hD000_0002);
        c = mk(MSG_CLAUSE,  4'd1, 8'd2, 32'hC000_00C1);
        for (int j = 0; j < 10; j++) d[j] = mk(MSG_DIVERGE, 4'd3, 8'd0, 32'hD000_0010 + j);
        exp_q = '{a, b, d[0], d[1], c, d[2]};
        out_if.ready = 1'b0;
        in_if.valid = 1'b1;
        in_if.pkt = a;
        tick();
        in_if.pkt = c;
        tick();
        in_if.pkt = b;
        tick();
        idx = 0;
        out_if.ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_if.pkt = d[idx];
            #1;
            acc = in_if.ready;
            if (out_if.valid === 1'b1) got.push_back(out_if.pkt);
            tick();
            if (acc && idx < 9) idx++;
        end
        in_if.valid = 1'b0;
        for (int cyc = 0; cyc < 12 && out_if.valid === 1'b1; cyc++) begin
            got.push_back(out_if.pkt);
            tick();
        end
        n_cmp++; if (got.size() != 3 + idx) begin n_bad++; $display("FAIL starve_total: got %0d want %0d", got.size(), 3 + idx); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= got.size()) begin
                n_bad++; $display("FAIL starve_order[%0d]: got none want %h", k, exp_q[k]);
            end else if (got[k] !== exp_q[k]) begin
                n_bad++; $display("FAIL starve_order[%0d]: got %h want %h", k, got[k], exp_q[k]);
            end
        end
        out_if.ready = 1'b0;
        n_cmp++; if (out_if.valid !== 1'b0 || {div_cnt, cls_cnt} !== 5'd0) begin n_bad++; $display("FAIL starve_empty: got %b/%0d/%0d want 0", out_if.valid, div_cnt, cls_cnt); end
    endtask

    task automatic test_reset_mid();
        noc_packet_t n;
        out_if.ready = 1'b0;
        in_if.valid = 1'b1;
        in_if.pkt = mk(MSG_DIVERGE, 4'd1, 8'd0, 32'hE000_0001);
        tick();
        in_if.pkt = mk(MSG_CLAUSE, 4'd1, 8'd1, 32'hE000_0002);
        tick();
        in_if.pkt = mk(MSG_DIVERGE, 4'd2, 8'd0, 32'hE000_0003);
        tick();
        in_if.valid = 1'b0;
        n_cmp++; if (out_if.valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", out_if.valid); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", out_if.valid); end
        n_cmp++; if ({div_cnt, cls_cnt} !== 5'd0) begin n_bad++; $display("FAIL midrst_counts: got %0d/%0d want 0", div_cnt, cls_cnt); end
        n_cmp++; if ({d_self, d_lbd, d_type} !== 48'd0) begin n_bad++; $display("FAIL midrst_drops: got %h/%h/%h want 0", d_self, d_lbd, d_type); end
        n_cmp++; if (out_if.pkt !== zero_pkt) begin n_bad++; $display("FAIL midrst_pkt: got %h want 0", out_if.pkt); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (out_if.valid !== 1'b0 || {div_cnt, cls_cnt} !== 5'd0) begin n_bad++; $display("FAIL midrst_stale: got %b/%0d/%0d want 0", out_if.valid, div_cnt, cls_cnt); end
        n = mk(MSG_CLAUSE, 4'd5, 8'd0, 32'h0000_BEEF);
        in_if.pkt = n;
        in_if.valid = 1'b1;
        tick();
        in_if.valid = 1'b0;
        tick();
        n_cmp++; if (out_if.valid !== 1'b1 || out_if.pkt !== n) begin n_bad++; $display("FAIL midrst_fresh: got %b/%h want 1/%h", out_if.valid, out_if.pkt, n); end
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
        n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL midrst_drained: got %b want 0", out_if.valid); end
    endtask

    initial begin
        test_reset();
        test_single_clause();
        test_drops();
        test_lbd_boundary();
        test_fill();
        test_no_preempt();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
